mem_arbiter: RTL and testbench

Sequences all traffic to the single-ported unified memory on behalf of the I-cache and D-cache miss paths. It accepts one line-fill request from each cache, plus an optional dirty-victim writeback from the D-cache. It grants the memory round-robin and performs writeback-then-fill for D-misses. It returns each filled line with a one-cycle done pulse. It sits between the cache controller and the unified memory, replacing direct memory-port sharing.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_rr_arb2.sv | 47 ++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter that serves
// the I-cache and D-cache miss paths.
package mem_arb_pkg;
    localparam int ADDR_W = 14;
    localparam int LINE_W = 64;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_FILL = 3'd1,
        ST_D_WB   = 3'd2,
        ST_D_FILL = 3'd3,
        ST_RESP_I = 3'd4,
        ST_RESP_D = 3'd5
    } state_e;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker. On a tie the grant goes to whichever
// requester was not served last; the last-grant register is loaded at response time.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic ireq_i,
    input  logic dreq_i,
    input  logic upd_i,
    input  logic upd_gnt_i,
    output logic valid_o,
    output logic gnt_o
);
    logic last_gnt_q;

    // Last-grant register; reset to GNT_I so the D side wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= GNT_I;
        end else if (upd_i) begin
            last_gnt_q <= upd_gnt_i;
        end else begin
            last_gnt_q <= last_gnt_q;
        end
    end

    // Grant selection, only meaningful while the arbiter is idle.
    always_comb begin
        valid_o = 1'b0;
        gnt_o   = GNT_D;
        if (en_i) begin
            valid_o = ireq_i | dreq_i;
            if (ireq_i && dreq_i) begin
                gnt_o = (last_gnt_q == GNT_D) ? GNT_I : GNT_D;
            end else if (ireq_i) begin
                gnt_o = GNT_I;
            end else begin
                gnt_o = GNT_D;
            end
        end else begin
            valid_o = 1'b0;
            gnt_o   = GNT_D;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Sequences I-fill, D-writeback and D-fill traffic onto the single-ported
// unified memory; every memory-side strobe and response output is registered.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_evict,
    input  logic [ADDR_W-1:0] d_evict_addr,
    input  logic [LINE_W-1:0] d_evict_data,
    output logic              i_done,
    output logic              d_done,
    output logic [LINE_W-1:0] fill_data,
    output logic              busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_rdy
);
    state_e            state_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [LINE_W-1:0] m_wdata_q;
    logic [LINE_W-1:0] fill_data_q;
    logic              m_re_q;
    logic              m_we_q;
    logic              i_done_q;
    logic              d_done_q;
    logic              busy_q;

    logic arb_en_s;
    logic arb_valid_s;
    logic arb_gnt_s;
    logic resp_upd_s;
    logic resp_gnt_s;

    assign arb_en_s   = (state_q == ST_IDLE);
    assign resp_upd_s = (state_q == ST_RESP_I) || (state_q == ST_RESP_D);
    assign resp_gnt_s = (state_q == ST_RESP_D) ? GNT_D : GNT_I;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .en_i      (arb_en_s),
        .ireq_i    (i_req),
        .dreq_i    (d_req),
        .upd_i     (resp_upd_s),
        .upd_gnt_i (resp_gnt_s),
        .valid_o   (arb_valid_s),
        .gnt_o     (arb_gnt_s)
    );

    // Main sequencer: state, capture registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            d_addr_q    <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            fill_data_q <= '0;
            m_re_q      <= 1'b0;
            m_we_q      <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        busy_q <= 1'b1;
                        if (arb_gnt_s == GNT_I) begin
                            state_q  <= ST_I_FILL;
                            m_re_q   <= 1'b1;
                            m_addr_q <= i_addr;
                        end else begin
                            // Fill address is held locally so the writeback can run first.
                            d_addr_q <= d_addr;
                            if (d_evict) begin
                                state_q   <= ST_D_WB;
                                m_we_q    <= 1'b1;
                                m_addr_q  <= d_evict_addr;
                                m_wdata_q <= d_evict_data;
                            end else begin
                                state_q  <= ST_D_FILL;
                                m_re_q   <= 1'b1;
                                m_addr_q <= d_addr;
                            end
                        end
                    end
                end
                ST_I_FILL: begin
                    if (m_rdy) begin
                        m_re_q      <= 1'b0;
                        fill_data_q <= m_rdata;
                        i_done_q    <= 1'b1;
                        state_q     <= ST_RESP_I;
                    end
                end
                ST_D_WB: begin
                    if (m_rdy) begin
                        m_we_q   <= 1'b0;
                        m_re_q   <= 1'b1;
                        m_addr_q <= d_addr_q;
                        state_q  <= ST_D_FILL;
                    end
                end
                ST_D_FILL: begin
                    if (m_rdy) begin
                        m_re_q      <= 1'b0;
                        fill_data_q <= m_rdata;
                        d_done_q    <= 1'b1;
                        state_q     <= ST_RESP_D;
                    end
                end
                ST_RESP_I, ST_RESP_D: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    m_re_q  <= 1'b0;
                    m_we_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign fill_data = fill_data_q;
    assign busy      = busy_q;
    assign m_addr    = m_addr_q;
    assign m_re      = m_re_q;
    assign m_we      = m_we_q;
    assign m_wdata   = m_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory responder, a transaction-level
// reference model feeding expected-op/expected-done queues, and a monitor.
module tb_mem_arbiter;
    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [63:0] data;
    } op_t;

    typedef struct packed {
        logic        is_d;
        logic [63:0] data;
    } dn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_evict;
    logic [13:0] i_addr, d_addr, d_evict_addr;
    logic [63:0] d_evict_data;
    logic        i_done, d_done, busy, m_re, m_we, m_rdy;
    logic [63:0] fill_data, m_wdata, m_rdata;
    logic [13:0] m_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int lat_cfg  = 0;
    int spur_cnt = 0;

    op_t exp_ops[$];
    dn_t exp_done[$];
    logic [63:0] store   [logic [13:0]];
    logic [63:0] ref_mem [logic [13:0]];
    logic        last_srv_d;
    logic [63:0] last_fill;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .d_evict(d_evict), .d_evict_addr(d_evict_addr), .d_evict_data(d_evict_data),
        .i_done(i_done), .d_done(d_done), .fill_data(fill_data), .busy(busy),
        .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rdy(m_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input logic [13:0] a);
        return {2'b00, a, 2'b11, ~a, 16'hC0DE, 2'b01, a ^ 14'h2AAA};
    endfunction

    function automatic logic [63:0] ref_rd(input logic [13:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Memory responder: serves each strobe after a latency, aborts on reset.
    initial begin : responder
        int spur_seen;
        int lat;
        logic        op_we, aborted;
        logic [13:0] op_addr;
        logic [63:0] op_wd;
        spur_seen = 0;
        m_rdy   = 1'b0;
        m_rdata = 64'h0;
        forever begin
            @(posedge clk); #1;
            m_rdy = 1'b0;
            if (spur_cnt != spur_seen && !busy) begin
                spur_seen = spur_cnt;
                m_rdata   = 64'hBAD0_BAD0_BAD0_BAD0;
                m_rdy     = 1'b1;
            end else if (!rst && (m_re || m_we)) begin
                op_we   = m_we;
                op_addr = m_addr;
                op_wd   = m_wdata;
                aborted = 1'b0;
                lat     = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 5));
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk); #1;
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    if (op_we) store[op_addr] = op_wd;
                    else m_rdata = store.exists(op_addr) ? store[op_addr] : init_word(op_addr);
                    m_rdy = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expected memory ops and done responses as the DUT presents them.
    initial begin : monitor
        logic prev_re, prev_we, prev_i, prev_d, prev_rdy_fill;
        op_t  op;
        dn_t  dn;
        prev_re = 1'b0; prev_we = 1'b0; prev_i = 1'b0; prev_d = 1'b0; prev_rdy_fill = 1'b0;
        forever begin
            @(negedge clk);
            check("strobe_excl", m_re && m_we, 1'b0);
            if (!rst) begin
                if ((m_re && !prev_re) || (m_we && !prev_we)) begin
                    if (exp_ops.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_op: got we=%0d addr=0x%0h, expected no operation", m_we, m_addr);
                    end else begin
                        op = exp_ops.pop_front();
                        check("op_kind", m_we, op.we);
                        check("op_addr", m_addr, op.addr);
                        if (op.we) check("op_wdata", m_wdata, op.data);
                    end
                end
                if (prev_rdy_fill) check("done_latency", i_done || d_done, 1'b1);
                if (i_done || d_done) begin
                    check("done_excl", i_done && d_done, 1'b0);
                    check("done_width", (i_done && prev_i) || (d_done && prev_d), 1'b0);
                    if (exp_done.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_done: got i_done=%0d d_done=%0d, expected none", i_done, d_done);
                    end else begin
                        dn = exp_done.pop_front();
                        check("done_who", d_done, dn.is_d);
                        check("fill_data", fill_data, dn.data);
                    end
                end
            end
            prev_re = m_re; prev_we = m_we; prev_i = i_done; prev_d = d_done;
            prev_rdy_fill = m_rdy && m_re;
        end
    end

    task automatic push_i(input logic [13:0] ia);
        exp_ops.push_back('{we: 1'b0, addr: ia, data: 64'h0});
        exp_done.push_back('{is_d: 1'b0, data: ref_rd(ia)});
        last_fill = ref_rd(ia);
    endtask

    task automatic push_d(input logic [13:0] da, input logic ev, input logic [13:0] ea, input logic [63:0] ed);
        if (ev) begin
            exp_ops.push_back('{we: 1'b1, addr: ea, data: ed});
            ref_mem[ea] = ed;
        end
        exp_ops.push_back('{we: 1'b0, addr: da, data: 64'h0});
        exp_done.push_back('{is_d: 1'b1, data: ref_rd(da)});
        last_fill = ref_rd(da);
    endtask

    // One round: raise the chosen requests, predict service order, hold until done.
    task automatic do_round(input logic ui, input logic ud, input logic early,
                            input logic [13:0] ia, input logic [13:0] da,
                            input logic [13:0] ea, input logic ev, input logic [63:0] ed);
        logic first_d, pend_i, pend_d;
        first_d = ud && (!ui || !last_srv_d);
        if (first_d) begin
            push_d(da, ev, ea, ed);
            if (ui) push_i(ia);
            last_srv_d = !ui;
        end else begin
            push_i(ia);
            if (ud) push_d(da, ev, ea, ed);
            last_srv_d = ud;
        end
        i_req = ui; i_addr = ia;
        d_req = ud; d_addr = da; d_evict = ev; d_evict_addr = ea; d_evict_data = ed;
        @(negedge clk);
        check("req_to_strobe", m_re || m_we, 1'b1);
        check("busy_set", busy, 1'b1);
        if (early) begin
            i_req = 1'b0;
            d_req = 1'b0;
        end
        pend_i = ui; pend_d = ud;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (i_done) begin pend_i = 1'b0; i_req = 1'b0; end
            if (d_done) begin pend_d = 1'b0; d_req = 1'b0; end
            if (!pend_i && !pend_d) break;
            @(negedge clk);
        end
        if (pend_i || pend_d) begin
            n_checks++; n_fail++;
            $display("FAIL round_timeout: got pending i=%0d d=%0d, expected both served", pend_i, pend_d);
            i_req = 1'b0; d_req = 1'b0;
        end
        @(negedge clk);
        check("busy_clear", busy, 1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [13:0] ra, rb, rc;
        int kind;
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_evict = 1'b0;
        i_addr = 14'h0; d_addr = 14'h0; d_evict_addr = 14'h0; d_evict_data = 64'h0;
        last_srv_d = 1'b0;
        last_fill  = 64'h0;
        repeat (3) @(negedge clk);
        check("rst_m_re", m_re, 1'b0);
        check("rst_m_we", m_we, 1'b0);
        check("rst_m_addr", m_addr, 14'h0);
        check("rst_m_wdata", m_wdata, 64'h0);
        check("rst_fill", fill_data, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", i_done || d_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous requests straight out of reset, three rounds.
        for (int r = 0; r < 3; r++)
            do_round(1'b1, 1'b1, 1'b0, 14'h0040 + 14'(r), 14'h0080 + 14'(r),
                     14'h00C0 + 14'(r), 1'(r), {32'hA5A5_0000, 32'(r)});

        lat_cfg = 4;
        store[14'h0010]   = 64'h1111_2222_3333_4444;
        ref_mem[14'h0010] = 64'h1111_2222_3333_4444;
        do_round(1'b1, 1'b0, 1'b0, 14'h0010, 14'h0, 14'h0, 1'b0, 64'h0);
        do_round(1'b0, 1'b1, 1'b0, 14'h0, 14'h0205, 14'h1A05, 1'b1, 64'hDEAD_BEEF_0000_FFFF);

        // Reset while the writeback is outstanding.
        lat_cfg = 8;
        exp_ops.push_back('{we: 1'b1, addr: 14'h1B00, data: 64'h0123_4567_89AB_CDEF});
        d_req = 1'b1; d_evict = 1'b1; d_addr = 14'h0300;
        d_evict_addr = 14'h1B00; d_evict_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        check("wb_strobe", m_we, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_we", m_we, 1'b0);
        check("rst_mid_re", m_re, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", i_done || d_done, 1'b0);
        rst = 1'b0; d_req = 1'b0; d_evict = 1'b0;
        last_srv_d = 1'b0;
        last_fill  = 64'h0;
        repeat (3) @(negedge clk);
        lat_cfg = 0;
        do_round(1'b1, 1'b0, 1'b0, 14'h1B00, 14'h0, 14'h0, 1'b0, 64'h0);

        // Stray m_rdy while idle must not disturb anything.
        spur_cnt++;
        repeat (4) @(negedge clk);
        check("spur_fill_hold", fill_data, last_fill);
        check("spur_busy", busy, 1'b0);
        do_round(1'b1, 1'b0, 1'b0, 14'h0022, 14'h0, 14'h0, 1'b0, 64'h0);

        for (int r = 0; r < 40; r++) begin
            kind = int'($urandom_range(0, 2));
            ra = 14'h0100 + 14'($urandom_range(0, 15));
            rb = 14'h0100 + 14'($urandom_range(0, 15));
            rc = 14'h0100 + 14'($urandom_range(0, 15));
            do_round(kind != 1, kind != 0, (kind != 2) && ($urandom_range(0, 3) == 0),
                     ra, rb, rc, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        repeat (5) @(negedge clk);
        check("ops_drained", 64'(exp_ops.size()), 64'h0);
        check("done_drained", 64'(exp_done.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
